sc_stream_decoder: RTL and testbench

//  Stochastic-to-binary converter: the decode end of the SC datapath. The encode end compares an

---
 rtl/sc_pkg.sv | 8 +
 rtl/sc_window_counter.sv | 20 ++
 rtl/sc_stream_decoder.sv | 49 ++++
 tb/tb_sc_stream_decoder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// sc_pkg: shared stochastic-computing types and helpers for the encode and decode ends.
package sc_pkg;
  localparam int SC_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} dec_state_t;
  function automatic int unsigned sc_window(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction
endpackage

// File: rtl/sc_window_counter.sv
// sc_window_counter: clear/enable counter whose last flag marks the increment that completes a window.
module sc_window_counter
  import sc_pkg::*;
#(
  parameter int WIDTH = SC_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             last
);
  localparam logic [WIDTH-1:0] TERM = WIDTH'(sc_window(WIDTH) - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clear) count <= '0;
    else if (inc) count <= count + 1'b1;
  assign last = inc && count == TERM;
endmodule

// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder: counts 1s over one full LFSR period of valid samples and reports the binary estimate.
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter int WIDTH      = SC_WIDTH,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] progress
);
  dec_state_t state;
  logic [WIDTH-1:0] prog_cnt, ones_cnt;
  logic run, take, prog_last, unused_ones_last;
  assign run  = state == RUN;
  assign take = run && !abort && bit_valid;
  // Counters sit cleared outside RUN, so every window starts from zero.
  sc_window_counter #(.WIDTH(WIDTH)) u_prog (
    .clk(clk), .reset(reset), .clear(!run), .inc(take), .count(prog_cnt), .last(prog_last)
  );
  sc_window_counter #(.WIDTH(WIDTH)) u_ones (
    .clk(clk), .reset(reset), .clear(!run), .inc(take && bit_in), .count(ones_cnt),
    .last(unused_ones_last)
  );
  assign busy     = run;
  assign progress = run ? prog_cnt : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
      value <= '0;
    end else begin
      done <= take && prog_last;
      // The final sample is still in flight in the ones counter, so add it here.
      if (take && prog_last) value <= ones_cnt + WIDTH'(bit_in);
      case (state)
        IDLE:    state <= start && !abort ? RUN : IDLE;
        RUN:     state <= abort ? IDLE : prog_last ? DONE : RUN;
        default: state <= CONTINUOUS && !abort ? RUN : IDLE;
      endcase
    end
endmodule

// File: tb/tb_sc_stream_decoder.sv
// tb_sc_stream_decoder: directed and random windows checked against a sample-counting reference model.
module tb_sc_stream_decoder;
  localparam int W = 8;
  localparam int N = 255;
  logic clk = 0, reset = 1, start = 0, start_c = 0, abort = 0, bit_in = 0, bit_valid = 0;
  logic busy, done, busy_c, done_c;
  logic [W-1:0] value, progress, value_c, progress_c;
  logic [31:0] prev = 0;
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  sc_stream_decoder #(.WIDTH(W), .CONTINUOUS(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .bit_in(bit_in),
    .bit_valid(bit_valid), .busy(busy), .done(done), .value(value), .progress(progress)
  );
  sc_stream_decoder #(.WIDTH(W), .CONTINUOUS(1'b1)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .abort(abort), .bit_in(bit_in),
    .bit_valid(bit_valid), .busy(busy_c), .done(done_c), .value(value_c), .progress(progress_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 ones, 1 zeros, 2 lfsr<128, 3 alternating with stalls, 4 random
  // kind: 0 complete window, 1 abort at stop_at, 2 reset at stop_at
  task automatic run(input int mode, input int stop_at, input int kind);
    logic b[$];
    logic v[$];
    logic [7:0] s = 8'h80;
    logic tog = 1'b1;
    int cnt = 0, ones = 0, k = -1, n = 0;
    for (int i = 0; i < 1000; i++) begin
      logic vb, bb;
      case (mode)
        0: begin vb = 1; bb = 1; end
        1: begin vb = 1; bb = 0; end
        2: begin vb = 1; bb = s < 8'd128; s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]}; end
        3: begin vb = (i % 3) != 2; bb = tog; if (vb) tog = ~tog; end
        default: begin vb = $urandom_range(3, 0) != 0; bb = 1'($urandom_range(1, 0)); end
      endcase
      b.push_back(bb);
      v.push_back(vb);
    end
    for (int i = 0; i < 1000 && k < 0; i++)
      if (v[i]) begin
        cnt++;
        ones += int'(b[i]);
        if (cnt == N) k = i;
      end
    bit_valid = 0;
    start = 1;
    tick();
    n++;
    start = 0;
    check("busy_after_start", busy, 1);
    check("progress_at_start", progress, 0);
    cnt = 0;
    for (int i = 0; i <= k; i++) begin
      bit_in = b[i];
      bit_valid = v[i];
      if (kind != 0 && cnt == stop_at) begin
        if (kind == 1) begin
          abort = 1;
          tick();
          abort = 0;
          bit_valid = 0;
          check("abort_busy", busy, 0);
          check("abort_done", done, 0);
          check("abort_progress", progress, 0);
          check("abort_value_held", value, prev);
          tick();
          check("abort_no_late_done", done, 0);
        end else begin
          reset = 1;
          #1;
          check("reset_busy", busy, 0);
          check("reset_done", done, 0);
          check("reset_value", value, 0);
          check("reset_progress", progress, 0);
          tick();
          reset = 0;
          bit_valid = 0;
          prev = 0;
        end
        return;
      end
      tick();
      n++;
      cnt += int'(v[i]);
      if (i < k) begin
        check("progress", progress, cnt);
        check("busy_run", busy, 1);
        check("done_early", done, 0);
      end
    end
    bit_valid = 0;
    check("done", done, 1);
    check("value", value, ones);
    check("latency", n, k + 2);
    check("busy_in_done", busy, 0);
    check("progress_in_done", progress, 0);
    prev = ones;
    tick();
    check("done_one_cycle", done, 0);
    check("value_held", value, ones);
  endtask

  initial begin
    int c;
    tick();
    tick();
    reset = 0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_value", value, 0);
    check("rst_progress", progress, 0);
    start = 1;
    abort = 1;
    tick();
    start = 0;
    abort = 0;
    check("abort_beats_start", busy, 0);
    run(0, -1, 0);
    run(1, -1, 0);
    run(2, -1, 0);
    run(3, -1, 0);
    run(4, -1, 0);
    run(4, -1, 0);
    run(0, 100, 1);
    run(0, -1, 0);
    run(1, 100, 2);
    check("post_reset_value", value, 0);
    start_c = 1;
    bit_in = 1;
    bit_valid = 1;
    for (int w = 0; w < 3; w++) begin
      c = 0;
      do begin
        tick();
        c++;
        start_c = c == 50;
      end while (!done_c && c < 400);
      start_c = 0;
      check("cont_period", c, 256);
      check("cont_value", value_c, N);
    end
    bit_valid = 0;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
